// File: rtl/quad_pkg.sv
`default_nettype none
// ============================================================================
// quad_pkg : step encoding, Gray-code step decode and saturating accumulate
// Rev 1.0
// ============================================================================
package quad_pkg;

    typedef enum logic [1:0] {
        STEP_NONE = 2'd0,
        STEP_FWD  = 2'd1,
        STEP_REV  = 2'd2,
        STEP_ERR  = 2'd3
    } step_e;

    localparam int SAT_W = 64;

    function automatic step_e decode_step(input logic [1:0] prev_ab, input logic [1:0] cur_ab);
        step_e s;
        case ({prev_ab, cur_ab})
            4'b0001, 4'b0111, 4'b1110, 4'b1000: s = STEP_FWD;
            4'b0010, 4'b1011, 4'b1101, 4'b0100: s = STEP_REV;
            4'b0011, 4'b1100, 4'b0110, 4'b1001: s = STEP_ERR;
            default:                            s = STEP_NONE;
        endcase
        return s;
    endfunction

    // Symmetric clamp at +/-(2^(width-1)-1); callers truncate to width.
    function automatic logic signed [SAT_W-1:0] sat_add(input logic signed [SAT_W-1:0] acc,
                                                        input logic signed [1:0]       inc,
                                                        input int unsigned              width);
        logic signed [SAT_W-1:0] lim;
        logic signed [SAT_W-1:0] sum;
        lim = (64'sd1 <<< (width - 1)) - 64'sd1;
        sum = acc + {{(SAT_W-2){inc[1]}}, inc};
        if (sum > lim) begin
            sum = lim;
        end else if (sum < -lim) begin
            sum = -lim;
        end
        return sum;
    endfunction

endpackage
`default_nettype wire

// File: rtl/quad_glitch_filter.sv
`default_nettype none
// ============================================================================
// quad_glitch_filter : 2-flop synchronizer plus persistence filter, one pin
// Rev 1.0
// ============================================================================
module quad_glitch_filter #(
    parameter int FILT_LEN = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic pin_i,
    output logic filt_o
);

    localparam int          CW       = 4;
    localparam logic [CW-1:0] CNT_LAST = CW'(FILT_LEN - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          filt_q;
    logic [CW-1:0] cnt_q;

    // cnt_q holds disagreeing samples already seen; the FILT_LEN-th one promotes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            filt_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= pin_i;
            sync2_q <= sync1_q;
            if (sync2_q == filt_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                filt_q <= sync2_q;
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign filt_o = filt_q;

endmodule
`default_nettype wire

// File: rtl/quad_decoder_core.sv
`default_nettype none
// ============================================================================
// quad_decoder_core : filtered A/B/I decode into position, velocity and flags
// Rev 1.0
// ============================================================================
module quad_decoder_core
    import quad_pkg::*;
#(
    parameter int CNT_WIDTH  = 32,
    parameter int FILT_LEN   = 4,
    parameter int VEL_WINDOW = 100000
) (
    input  logic                 ACLK,
    input  logic                 ARESETN,
    input  logic                 enc_a,
    input  logic                 enc_b,
    input  logic                 enc_i,
    input  logic                 en,
    input  logic                 clr_pos,
    input  logic                 idx_clr_en,
    input  logic                 clr_err,
    output logic [CNT_WIDTH-1:0] position,
    output logic [CNT_WIDTH-1:0] velocity,
    output logic                 vel_valid,
    output logic                 dir,
    output logic                 err,
    output logic                 idx_seen
);

    localparam int               WIN_W    = $clog2(VEL_WINDOW);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(VEL_WINDOW - 1);

    logic a_filt, b_filt, i_filt;

    quad_glitch_filter #(.FILT_LEN(FILT_LEN)) u_filt_a (.clk_i(ACLK), .rst_ni(ARESETN), .pin_i(enc_a), .filt_o(a_filt));
    quad_glitch_filter #(.FILT_LEN(FILT_LEN)) u_filt_b (.clk_i(ACLK), .rst_ni(ARESETN), .pin_i(enc_b), .filt_o(b_filt));
    quad_glitch_filter #(.FILT_LEN(FILT_LEN)) u_filt_i (.clk_i(ACLK), .rst_ni(ARESETN), .pin_i(enc_i), .filt_o(i_filt));

    logic [1:0]           prev_ab_q;
    logic                 prev_i_q;
    step_e                step_q, step_d;
    logic                 idx_rise_q, idx_rise_d;
    logic [CNT_WIDTH-1:0] pos_q, pos_d;
    logic [CNT_WIDTH-1:0] vel_q, vel_d;
    logic [CNT_WIDTH-1:0] acc_q, acc_d;
    logic [WIN_W-1:0]     win_q, win_d;
    logic                 vel_valid_q, vel_valid_d;
    logic                 dir_q, dir_d;
    logic                 err_q, err_d;
    logic                 idx_seen_q, idx_seen_d;

    logic signed [1:0]       step_inc;
    logic signed [SAT_W-1:0] acc_ext;
    logic [CNT_WIDTH-1:0]    acc_next;

    // The decoded step is registered so the index edge and the step stay aligned.
    assign step_d     = decode_step(prev_ab_q, {a_filt, b_filt});
    assign idx_rise_d = i_filt & ~prev_i_q;

    assign step_inc = !en                  ? 2'sb00 :
                      (step_q == STEP_FWD) ? 2'sb01 :
                      (step_q == STEP_REV) ? 2'sb11 : 2'sb00;
    assign acc_ext  = {{(SAT_W-CNT_WIDTH){acc_q[CNT_WIDTH-1]}}, acc_q};
    assign acc_next = CNT_WIDTH'(sat_add(acc_ext, step_inc, CNT_WIDTH));

    always_comb begin
        pos_d       = pos_q;
        vel_d       = vel_q;
        acc_d       = '0;
        win_d       = '0;
        vel_valid_d = 1'b0;
        dir_d       = dir_q;
        err_d       = err_q;
        idx_seen_d  = idx_seen_q | idx_rise_q;

        if (clr_err) err_d = 1'b0;
        if (en && step_q == STEP_ERR) err_d = 1'b1;

        if (clr_pos || (idx_clr_en && idx_rise_q)) begin
            pos_d = '0;
        end else begin
            pos_d = pos_q + {{(CNT_WIDTH-2){step_inc[1]}}, step_inc};
        end

        if (en && step_q == STEP_FWD) dir_d = 1'b1;
        if (en && step_q == STEP_REV) dir_d = 1'b0;

        if (en) begin
            if (win_q == WIN_LAST) begin
                vel_d       = acc_next;
                vel_valid_d = 1'b1;
            end else begin
                acc_d = acc_next;
                win_d = win_q + WIN_W'(1);
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            prev_ab_q   <= 2'b00;
            prev_i_q    <= 1'b0;
            step_q      <= STEP_NONE;
            idx_rise_q  <= 1'b0;
            pos_q       <= '0;
            vel_q       <= '0;
            acc_q       <= '0;
            win_q       <= '0;
            vel_valid_q <= 1'b0;
            dir_q       <= 1'b0;
            err_q       <= 1'b0;
            idx_seen_q  <= 1'b0;
        end else begin
            prev_ab_q   <= {a_filt, b_filt};
            prev_i_q    <= i_filt;
            step_q      <= step_d;
            idx_rise_q  <= idx_rise_d;
            pos_q       <= pos_d;
            vel_q       <= vel_d;
            acc_q       <= acc_d;
            win_q       <= win_d;
            vel_valid_q <= vel_valid_d;
            dir_q       <= dir_d;
            err_q       <= err_d;
            idx_seen_q  <= idx_seen_d;
        end
    end

    assign position  = pos_q;
    assign velocity  = vel_q;
    assign vel_valid = vel_valid_q;
    assign dir       = dir_q;
    assign err       = err_q;
    assign idx_seen  = idx_seen_q;

endmodule
`default_nettype wire

// File: tb/tb_quad_decoder_core.sv
`default_nettype none
// ============================================================================
// tb_quad_decoder_core : directed vectors with hand-computed expectations
// Rev 1.0
// ============================================================================
module tb_quad_decoder_core;

    logic ACLK = 1'b0;
    logic ARESETN, enc_a, enc_b, enc_i, en, clr_pos, idx_clr_en, clr_err;

    logic [31:0] position, velocity;
    logic        vel_valid, dir, err, idx_seen;

    logic [3:0]  position_n, velocity_n;
    logic        vel_valid_n, dir_n, err_n, idx_seen_n;

    int n_vec = 0;
    int n_err = 0;

    logic [1:0] fwd_seq [4];
    logic       seen;

    always #5 ACLK = ~ACLK;

    quad_decoder_core #(.CNT_WIDTH(32), .FILT_LEN(4), .VEL_WINDOW(16)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .enc_a(enc_a), .enc_b(enc_b), .enc_i(enc_i),
        .en(en), .clr_pos(clr_pos), .idx_clr_en(idx_clr_en), .clr_err(clr_err),
        .position(position), .velocity(velocity), .vel_valid(vel_valid),
        .dir(dir), .err(err), .idx_seen(idx_seen)
    );

    // Narrow copy exercises the two's-complement wrap at the positive limit.
    quad_decoder_core #(.CNT_WIDTH(4), .FILT_LEN(4), .VEL_WINDOW(16)) dut_n (
        .ACLK(ACLK), .ARESETN(ARESETN), .enc_a(enc_a), .enc_b(enc_b), .enc_i(enc_i),
        .en(en), .clr_pos(clr_pos), .idx_clr_en(idx_clr_en), .clr_err(clr_err),
        .position(position_n), .velocity(velocity_n), .vel_valid(vel_valid_n),
        .dir(dir_n), .err(err_n), .idx_seen(idx_seen_n)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge ACLK);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        fwd_seq = '{2'b01, 2'b11, 2'b10, 2'b00};
        ARESETN = 0; enc_a = 0; enc_b = 0; enc_i = 0;
        en = 0; clr_pos = 0; idx_clr_en = 0; clr_err = 0;
        tick(3);
        chk ("rst_position", position, 32'h0);
        chk ("rst_velocity", velocity, 32'h0);
        chk1("rst_vel_valid", vel_valid, 1'b0);
        chk1("rst_dir", dir, 1'b0);
        chk1("rst_err", err, 1'b0);
        chk1("rst_idx_seen", idx_seen, 1'b0);
        ARESETN = 1;
        tick(2);

        // Four forward Gray steps, each landing on the 8th edge (k+7)
        en = 1;
        for (int s = 0; s < 4; s++) begin
            {enc_a, enc_b} = fwd_seq[s];
            tick(7);
            chk($sformatf("fwd_hold%0d", s), position, 32'(s));
            tick(1);
            chk($sformatf("fwd_step%0d", s), position, 32'(s + 1));
            tick(2);
        end
        chk1("fwd_dir", dir, 1'b1);

        // 3-cycle glitches are rejected; a 4-cycle pulse on A passes both edges
        enc_a = 1; tick(3); enc_a = 0; tick(12);
        enc_b = 1; tick(3); enc_b = 0; tick(12);
        chk("glitch_reject", position, 32'd4);
        enc_b = 1; tick(10);
        chk("b_step", position, 32'd5);
        enc_a = 1; tick(4); enc_a = 0; tick(4);
        chk ("pulse_up", position, 32'd6);
        chk1("pulse_up_dir", dir, 1'b1);
        tick(4);
        chk ("pulse_dn", position, 32'd5);
        chk1("pulse_dn_dir", dir, 1'b0);

        // Illegal transitions and err priority
        chk1("err_clean", err, 1'b0);
        {enc_a, enc_b} = 2'b10; tick(10);
        chk1("illegal_err", err, 1'b1);
        chk ("illegal_pos", position, 32'd5);
        {enc_a, enc_b} = 2'b01; tick(7);
        clr_err = 1; tick(1); clr_err = 0;
        chk1("err_set_wins", err, 1'b1);
        tick(3);
        clr_err = 1; tick(1); clr_err = 0;
        chk1("err_cleared", err, 1'b0);
        chk ("err_pos", position, 32'd5);

        // Wrap: 0 - 1 on the wide core, +7 -> +8 on the narrow core
        clr_pos = 1; tick(1); clr_pos = 0;
        chk("clr_pos", position, 32'h0);
        chk("clr_pos_n", 32'(position_n), 32'h0);
        enc_b = 0; tick(10);
        chk ("wrap_neg", position, 32'hFFFF_FFFF);
        chk ("wrap_neg_n", 32'(position_n), 32'h0000_000F);
        chk1("wrap_neg_dir", dir, 1'b0);
        clr_pos = 1; tick(1); clr_pos = 0;
        for (int s = 0; s < 7; s++) begin
            {enc_a, enc_b} = fwd_seq[s % 4];
            tick(10);
        end
        chk("narrow_max", 32'(position_n), 32'h0000_0007);
        {enc_a, enc_b} = fwd_seq[3];
        tick(10);
        chk("narrow_wrap", 32'(position_n), 32'h0000_0008);
        chk("wide_eight", position, 32'd8);

        // Index clear coincident with a forward step; clr_pos with a step
        chk1("idx_seen_pre", idx_seen, 1'b0);
        idx_clr_en = 1; enc_i = 1; enc_b = 1; tick(10);
        chk ("idx_clear", position, 32'h0);
        chk1("idx_seen", idx_seen, 1'b1);
        enc_i = 0; tick(10); idx_clr_en = 0;
        enc_a = 1; tick(10);
        chk("post_idx_step", position, 32'd1);
        enc_b = 0; tick(7);
        clr_pos = 1; tick(1); clr_pos = 0;
        chk("clr_pos_drops_step", position, 32'h0);
        tick(2);

        // Velocity: three steps land on edges 5, 10, 15 of the first window
        en = 0; tick(2);
        enc_a = 0; tick(3);
        en = 1; tick(2);
        enc_b = 1; tick(5);
        enc_a = 1; tick(8);
        chk1("vel_not_yet", vel_valid, 1'b0);
        tick(1);
        chk1("vel_valid", vel_valid, 1'b1);
        chk ("vel_three", velocity, 32'd3);
        chk ("vel_pos", position, 32'd3);
        tick(1);
        chk1("vel_valid_pulse", vel_valid, 1'b0);

        // Disable mid-window: no strobe, velocity holds
        tick(4);
        en = 0;
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick(1);
            seen = seen | vel_valid;
        end
        chk1("en_off_no_valid", seen, 1'b0);
        chk ("en_off_vel_hold", velocity, 32'd3);

        // Re-enable: a fresh window, one step, strobe exactly 16 cycles later
        en = 1; enc_b = 0;
        seen = 1'b0;
        for (int c = 0; c < 15; c++) begin
            tick(1);
            seen = seen | vel_valid;
        end
        chk1("fresh_no_early", seen, 1'b0);
        tick(1);
        chk1("fresh_valid", vel_valid, 1'b1);
        chk ("fresh_vel_one", velocity, 32'd1);
        chk ("fresh_pos", position, 32'd4);

        // Asynchronous reset mid-operation
        ARESETN = 0;
        #2;
        chk ("async_rst_pos", position, 32'h0);
        chk ("async_rst_vel", velocity, 32'h0);
        chk1("async_rst_idx", idx_seen, 1'b0);
        chk1("async_rst_dir", dir, 1'b0);
        tick(2);
        ARESETN = 1;
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
